// File: rtl/bcd_display_pkg.sv
// ============================================================================
//  Module      : bcd_display_pkg
//  Description : Shared types and constants for the BCD display controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam logic [13:0] MAX_BCD4  = 14'd9999;

    // Segment order is {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;

    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
//  Module      : seg7_decode
//  Description : BCD digit to active-low seven-segment pattern, with blank
//                and dash overrides (dash wins). Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode (
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    input  logic       i_dash,
    output logic [6:0] o_seg
);
    import bcd_display_pkg::*;

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_dash) begin
            o_seg = SEG_DASH;
        end else if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = 7'b1000000;
                4'd1:    o_seg = 7'b1111001;
                4'd2:    o_seg = 7'b0100100;
                4'd3:    o_seg = 7'b0110000;
                4'd4:    o_seg = 7'b0011001;
                4'd5:    o_seg = 7'b0010010;
                4'd6:    o_seg = 7'b0000010;
                4'd7:    o_seg = 7'b1111000;
                4'd8:    o_seg = 7'b0000000;
                4'd9:    o_seg = 7'b0010000;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_display_ctrl.sv
// ============================================================================
//  Module      : bcd_display_ctrl
//  Description : Sequences bcd4digit conversions (coalescing updates while
//                busy), latches result digits and scans a 4-digit display.
//                Define BCD_DISPLAY_BLANK_EN to blank leading zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_display_ctrl
    import bcd_display_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int CONV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    input  logic        update,
    output logic        conv_start,
    output logic [13:0] conv_value,
    input  logic        conv_ready,
    input  logic [3:0]  conv_A,
    input  logic [3:0]  conv_B,
    input  logic [3:0]  conv_C,
    input  logic [3:0]  conv_D,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        busy,
    output logic        err
);

    localparam int              PRE_W    = $clog2(SCAN_DIV);
    localparam int              TMO_W    = $clog2(CONV_TIMEOUT);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CONV_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [13:0]       next_val_q, next_val_d;
    logic [13:0]       conv_value_q, conv_value_d;
    logic              conv_start_q, conv_start_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [3:0][3:0]   dig_q, dig_d;        // [3]=A (thousands) .. [0]=D (units)
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic              w_req;
    logic [13:0]       w_cand;
    logic [3:0]        w_lead;
    logic [6:0]        w_seg;

    // A pending value takes precedence; a fresh update then re-arms pend.
    assign w_req  = pend_q | update;
    assign w_cand = pend_q ? next_val_q : value;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        next_val_d   = next_val_q;
        conv_value_d = conv_value_q;
        err_d        = err_q;
        ovf_d        = ovf_q;
        tmo_d        = tmo_q;
        dig_d        = dig_q;

        case (state_q)
            IDLE: begin
                if (w_req) begin
                    pend_d = 1'b0;
                    if (w_cand > MAX_BCD4) begin
                        ovf_d = 1'b1;
                    end else begin
                        state_d      = START;
                        conv_value_d = w_cand;
                    end
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // conv_ready may still be stale in the first WAIT cycle.
                if ((tmo_q != '0) && conv_ready) begin
                    state_d = LATCH;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            LATCH: begin
                dig_d   = {conv_A, conv_B, conv_C, conv_D};
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (update) begin
            next_val_d = value;
            if (!((state_q == IDLE) && !pend_q)) begin
                pend_d = 1'b1;
            end
        end
    end

    assign conv_start_d = (state_d == START);
    assign busy_d       = (state_d != IDLE);

`ifdef BCD_DISPLAY_BLANK_EN
    assign w_lead[3] = (dig_d[3] == 4'd0);
    assign w_lead[2] = w_lead[3] && (dig_d[2] == 4'd0);
    assign w_lead[1] = w_lead[2] && (dig_d[1] == 4'd0);
    assign w_lead[0] = 1'b0;
`else
    assign w_lead    = 4'b0000;
`endif

    // Decode from next-state digits so a LATCH shows up without a stale cycle.
    seg7_decode u_seg7_decode (
        .i_bcd   (dig_d[idx_q]),
        .i_blank (w_lead[idx_q]),
        .i_dash  (ovf_d),
        .o_seg   (w_seg)
    );

    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = idx_q + 2'd1;
        end
        an_d  = anode_for(idx_q);
        seg_d = w_seg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_q       <= 1'b0;
            next_val_q   <= '0;
            conv_value_q <= '0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            tmo_q        <= '0;
            dig_q        <= '0;
            pre_q        <= '0;
            idx_q        <= 2'd0;
            an_q         <= 4'b1111;
            seg_q        <= SEG_BLANK;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            next_val_q   <= next_val_d;
            conv_value_q <= conv_value_d;
            conv_start_q <= conv_start_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
            tmo_q        <= tmo_d;
            dig_q        <= dig_d;
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign conv_start = conv_start_q;
    assign conv_value = conv_value_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign an         = an_q;
    assign seg        = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_ctrl.sv
// ============================================================================
//  Module      : tb_bcd_display_ctrl
//  Description : Directed bench for bcd_display_ctrl with a behavioural
//                30-cycle bcd4digit model. Honours BCD_DISPLAY_BLANK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_display_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int TMO      = 40;
    localparam int LAT      = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] value = '0;
    logic        update = 1'b0;
    logic        conv_start;
    logic [13:0] conv_value;
    logic        conv_ready = 1'b0;
    logic [3:0]  c_a = '0, c_b = '0, c_c = '0, c_d = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        busy, err;

    int          total = 0;
    int          bad   = 0;
    logic        dead  = 1'b0;
    logic        clr   = 1'b0;
    int          cnt   = 0;
    int          op    = 0;
    logic [13:0] starts[$];

    always #5 clk = ~clk;

    bcd_display_ctrl #(.SCAN_DIV(SCAN_DIV), .CONV_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .value(value), .update(update),
        .conv_start(conv_start), .conv_value(conv_value), .conv_ready(conv_ready),
        .conv_A(c_a), .conv_B(c_b), .conv_C(c_c), .conv_D(c_d),
        .an(an), .seg(seg), .busy(busy), .err(err)
    );

    // Converter model: ready stays stale through the first cycle after start.
    always @(posedge clk) begin
        if (rst) begin
            conv_ready <= 1'b0; clr <= 1'b0; cnt <= 0;
            c_a <= '0; c_b <= '0; c_c <= '0; c_d <= '0;
        end else if (conv_start) begin
            clr <= 1'b1;
            op  <= int'(conv_value);
        end else if (clr) begin
            clr <= 1'b0; conv_ready <= 1'b0; cnt <= LAT;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1 && !dead) begin
                conv_ready <= 1'b1;
                c_a <= 4'(op / 1000);
                c_b <= 4'((op / 100) % 10);
                c_c <= 4'((op / 10) % 10);
                c_d <= 4'(op % 10);
            end
        end
    end

    always @(negedge clk) if (!rst && conv_start === 1'b1) starts.push_back(conv_value);

    function automatic logic [6:0] s7(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int v);
        value  = 14'(v);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int i;
        i = 0;
        while (i < 200 && conv_ready !== 1'b1) begin @(negedge clk); i++; end
        chk({tag, "_ready"}, conv_ready, 1);
    endtask

    task automatic wait_idle(input string tag);
        int i, quiet;
        i = 0; quiet = 0;
        while (i < 400 && quiet < 3) begin
            @(negedge clk); i++;
            quiet = (busy === 1'b0) ? quiet + 1 : 0;
        end
        chk({tag, "_idle"}, quiet, 3);
    endtask

    task automatic check_display(input string tag, input logic [6:0] ea, input logic [6:0] eb,
                                 input logic [6:0] ec, input logic [6:0] ed);
        logic [6:0] es[4];
        logic [3:0] ean[4];
        logic [3:0] prev;
        int i;
        es  = '{ed, ec, eb, ea};
        ean = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        prev = an; i = 0;
        while (i < 64 && !(prev != 4'b1110 && an == 4'b1110)) begin
            prev = an; @(negedge clk); i++;
        end
        chk({tag, "_sync"}, an, 4'b1110);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_an%0d", tag, k), an, ean[k / 4]);
            chk($sformatf("%s_seg%0d", tag, k), seg, es[k / 4]);
            @(negedge clk);
        end
    endtask

    task automatic check_num(input string tag, input int n);
        int d[4];
        logic [6:0] e[4];
`ifdef BCD_DISPLAY_BLANK_EN
        bit lead;
`endif
        d[3] = n / 1000; d[2] = (n / 100) % 10; d[1] = (n / 10) % 10; d[0] = n % 10;
        for (int k = 0; k < 4; k++) e[k] = s7(d[k]);
`ifdef BCD_DISPLAY_BLANK_EN
        lead = 1'b1;
        for (int k = 3; k > 0; k--) begin
            lead = lead && (d[k] == 0);
            if (lead) e[k] = 7'b1111111;
        end
`endif
        check_display(tag, e[3], e[2], e[1], e[0]);
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("rst_an", an, 4'b1111);
        chk("rst_seg", seg, 7'b1111111);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_start", conv_start, 0);
        chk("rst_cval", conv_value, 0);
        rst = 1'b0;
        cyc(1);
        chk("first_an", an, 4'b1110);
        chk("first_seg", seg, s7(0));

        // Single conversion, start latency and busy release
        send(4934);
        chk("c1_start", conv_start, 1);
        chk("c1_cval", conv_value, 4934);
        chk("c1_busy", busy, 1);
        cyc(1);
        chk("c1_pulse", conv_start, 0);
        wait_ready("c1");
        chk("c1_busy_r", busy, 1);
        cyc(1);
        chk("c1_busy_latch", busy, 1);
        cyc(1);
        chk("c1_busy_drop", busy, 0);
        check_num("d4934", 4934);

        // Update during WAIT: back-to-back restart at LATCH+2
        starts.delete();
        send(1234);
        cyc(5);
        send(5678);
        wait_ready("c2");
        cyc(2);
        chk("b2b_gap", conv_start, 0);
        cyc(1);
        chk("b2b_start", conv_start, 1);
        chk("b2b_cval", conv_value, 5678);
        wait_idle("c2");
        chk("c2_n", starts.size(), 2);
        chk("c2_v0", starts[0], 1234);
        chk("c2_v1", starts[1], 5678);
        check_num("d5678", 5678);

        // Coalescing: only the last of several busy-time updates converts
        starts.delete();
        send(1111);
        cyc(3);
        send(2222);
        send(3333);
        cyc(2);
        send(4444);
        wait_idle("c3");
        chk("c3_n", starts.size(), 2);
        chk("c3_v0", starts[0], 1111);
        chk("c3_v1", starts[1], 4444);
        check_num("d4444", 4444);

        // Overflow: no conversion, dashes on every digit
        starts.delete();
        send(12000);
        chk("ovf_start", conv_start, 0);
        chk("ovf_busy", busy, 0);
        cyc(3);
        chk("ovf_n", starts.size(), 0);
        check_display("dash", 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
        send(7);
        wait_idle("c7");
        check_num("d7", 7);

        // Timeout: err after CONV_TIMEOUT WAIT cycles, digits retained
        dead = 1'b1;
        send(4321);
        chk("tmo_start", conv_start, 1);
        cyc(TMO);
        chk("tmo_err_pre", err, 0);
        chk("tmo_busy_pre", busy, 1);
        cyc(1);
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        dead = 1'b0;
        check_num("tmo_keep", 7);
        send(55);
        wait_idle("c55");
        check_num("d55", 55);
        chk("err_sticky", err, 1);

        // Reset during WAIT
        send(8888);
        cyc(5);
        rst = 1'b1;
        cyc(1);
        chk("mid_an", an, 4'b1111);
        chk("mid_seg", seg, 7'b1111111);
        chk("mid_busy", busy, 0);
        chk("mid_err", err, 0);
        chk("mid_start", conv_start, 0);
        rst = 1'b0;
        cyc(1);
        chk("mid_first_an", an, 4'b1110);
        chk("mid_first_seg", seg, s7(0));
        send(9);
        chk("post_start", conv_start, 1);
        wait_idle("c9");
        check_num("d9", 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
